// File: rtl/jtkunio_colmix.sv
// Final colour mixer: layer priority, 256x12 CPU-writable palette, gated 4-4-4 RGB
// output, with the blanking inputs delayed to line up with the colour pipeline.
module jtkunio_colmix #(
  parameter int unsigned BLANK_DLY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [5:0] scr_pxl,
  input  logic [5:0] char_pxl,
  input  logic [6:0] obj_pxl,
  input  logic [8:0] cpu_addr,
  input  logic       pal_cs,
  input  logic       cpu_wrn,
  input  logic [7:0] cpu_dout,
  output logic [7:0] cpu_din,
  input  logic [2:0] gfx_en,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  logic [11:0]          pal_mem [0:255];
  logic [11:0]          vid_q;
  logic [7:0]           idx_q, idx_d;
  logic                 none_q, none_d;
  logic                 rd_q, rd_d;
  logic [BLANK_DLY-1:0] hbl_q, hbl_d, vbl_q, vbl_d;
  logic [11:0]          rgb_q, rgb_d;
  logic [7:0]           cpu_din_q, cpu_din_d;
  logic                 char_on, obj_on, scr_on, blank_ok;
  logic [11:0]          cpu_word;

  always_comb begin
    char_on  = gfx_en[0] && (char_pxl[1:0] != 2'd0);
    obj_on   = gfx_en[2] && (obj_pxl[2:0] != 3'd0);
    scr_on   = gfx_en[1];
    idx_d    = idx_q;
    none_d   = none_q;
    hbl_d    = hbl_q;
    vbl_d    = vbl_q;
    rgb_d    = rgb_q;
    rd_d     = pxl_cen;
    blank_ok = 1'b0;
    if (pxl_cen) begin
      none_d = 1'b0;
      if (char_on)     idx_d = {2'b00, char_pxl};
      else if (obj_on) idx_d = {1'b1, obj_pxl};
      else if (scr_on) idx_d = {2'b01, scr_pxl};
      else begin
        idx_d  = '0;
        none_d = 1'b1;
      end
      hbl_d[0] = LHBL;
      vbl_d[0] = LVBL;
      for (int unsigned i = 1; i < BLANK_DLY; i++) begin
        hbl_d[i] = hbl_q[i-1];
        vbl_d[i] = vbl_q[i-1];
      end
      // Gate with the blank value that becomes visible on this same edge
      blank_ok = hbl_d[BLANK_DLY-1] & vbl_d[BLANK_DLY-1];
      rgb_d    = (none_q || !blank_ok) ? '0 : vid_q;
    end
  end

  always_comb begin
    cpu_word  = pal_mem[cpu_addr[7:0]];
    cpu_din_d = cpu_addr[8] ? {4'h0, cpu_word[3:0]} : cpu_word[11:4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      none_q    <= 1'b0;
      rd_q      <= 1'b0;
      hbl_q     <= '0;
      vbl_q     <= '0;
      rgb_q     <= '0;
      cpu_din_q <= '0;
    end else begin
      idx_q     <= idx_d;
      none_q    <= none_d;
      rd_q      <= rd_d;
      hbl_q     <= hbl_d;
      vbl_q     <= vbl_d;
      rgb_q     <= rgb_d;
      cpu_din_q <= cpu_din_d;
    end
  end

  // Video port reads once, one clk after the index is latched; a write on that
  // same edge is seen by the following pixel only.
  always_ff @(posedge clk) begin
    if (pal_cs && !cpu_wrn) begin
      if (cpu_addr[8]) pal_mem[cpu_addr[7:0]][3:0]  <= cpu_dout[3:0];
      else             pal_mem[cpu_addr[7:0]][11:4] <= cpu_dout;
    end
    if (rd_q) vid_q <= pal_mem[idx_q];
  end

  assign red      = rgb_q[11:8];
  assign green    = rgb_q[7:4];
  assign blue     = rgb_q[3:0];
  assign LHBL_dly = hbl_q[BLANK_DLY-1];
  assign LVBL_dly = vbl_q[BLANK_DLY-1];
  assign cpu_din  = cpu_din_q;

endmodule
